// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto a table of voice slots,
// reusing matching voices, filling free ones first, and stealing the oldest when full.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              data_valid_in,
    input  logic [7:0]                        note_in,
    input  logic [7:0]                        velocity_in,
    input  logic [3:0]                        channel_in,
    input  logic                              status_in,
    output logic [NUM_VOICES-1:0]             voice_active_out,
    output logic [NUM_VOICES*7-1:0]           voice_note_out,
    output logic [NUM_VOICES*7-1:0]           voice_velocity_out,
    output logic [NUM_VOICES*4-1:0]           voice_channel_out,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count_out,
    output logic                              update_out,
    output logic [$clog2(NUM_VOICES)-1:0]     update_voice_out,
    output logic                              stolen_out,
    output logic                              dropped_out
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} state_t;

    state_t                 state;
    logic [6:0]             ev_note;
    logic [6:0]             ev_vel;
    logic [3:0]             ev_chan;
    logic                   ev_on;

    logic [NUM_VOICES-1:0]  active_q;
    logic [6:0]             note_q [NUM_VOICES];
    logic [6:0]             vel_q  [NUM_VOICES];
    logic [3:0]             chan_q [NUM_VOICES];
    logic [AGE_W-1:0]       age_q  [NUM_VOICES];

    logic                   match_hit_q, free_hit_q;
    logic [IDX_W-1:0]       match_idx_q, free_idx_q, old_idx_q;

    logic                   match_hit_c, free_hit_c, old_hit_c;
    logic [IDX_W-1:0]       match_idx_c, free_idx_c, old_idx_c;
    logic [AGE_W-1:0]       old_age_c;

    logic                   wr_en_c, steal_c;
    logic [IDX_W-1:0]       wr_idx_c;
    logic [NUM_VOICES-1:0]  next_active_c;
    logic [CNT_W-1:0]       count_c;

    // Velocity MSB is outside the stored 7-bit range.
    logic unused_vel_msb;
    assign unused_vel_msb = velocity_in[7];

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note_out[g*7 +: 7]     = note_q[g];
        assign voice_velocity_out[g*7 +: 7] = vel_q[g];
        assign voice_channel_out[g*4 +: 4]  = chan_q[g];
    end
    assign voice_active_out = active_q;

    // Scan the table for a matching voice, the lowest free voice and the oldest active voice.
    always_comb begin
        match_hit_c = 1'b0;
        match_idx_c = '0;
        free_hit_c  = 1'b0;
        free_idx_c  = '0;
        old_hit_c   = 1'b0;
        old_idx_c   = '0;
        old_age_c   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && !match_hit_c && note_q[i] == ev_note && chan_q[i] == ev_chan) begin
                match_hit_c = 1'b1;
                match_idx_c = IDX_W'(i);
            end
            if (!active_q[i] && !free_hit_c) begin
                free_hit_c = 1'b1;
                free_idx_c = IDX_W'(i);
            end
            if (active_q[i] && (!old_hit_c || age_q[i] > old_age_c)) begin
                old_hit_c = 1'b1;
                old_age_c = age_q[i];
                old_idx_c = IDX_W'(i);
            end
        end
    end

    // Pick the write target from the registered search results and predict the new occupancy.
    always_comb begin
        wr_en_c  = 1'b0;
        wr_idx_c = '0;
        steal_c  = 1'b0;
        if (ev_on) begin
            wr_en_c = 1'b1;
            if (match_hit_q) begin
                wr_idx_c = match_idx_q;
            end else if (free_hit_q) begin
                wr_idx_c = free_idx_q;
            end else begin
                wr_idx_c = old_idx_q;
                steal_c  = 1'b1;
            end
        end else if (match_hit_q) begin
            wr_en_c  = 1'b1;
            wr_idx_c = match_idx_q;
        end
        next_active_c = active_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (wr_en_c && IDX_W'(i) == wr_idx_c) begin
                next_active_c[i] = ev_on;
            end
        end
        count_c = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_c = count_c + CNT_W'(next_active_c[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            ev_note          <= '0;
            ev_vel           <= '0;
            ev_chan          <= '0;
            ev_on            <= 1'b0;
            active_q         <= '0;
            match_hit_q      <= 1'b0;
            free_hit_q       <= 1'b0;
            match_idx_q      <= '0;
            free_idx_q       <= '0;
            old_idx_q        <= '0;
            active_count_out <= '0;
            update_out       <= 1'b0;
            update_voice_out <= '0;
            stolen_out       <= 1'b0;
            dropped_out      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                chan_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            update_out       <= 1'b0;
            update_voice_out <= '0;
            stolen_out       <= 1'b0;
            dropped_out      <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid_in && !note_in[7]) begin
                        ev_note <= note_in[6:0];
                        ev_vel  <= velocity_in[6:0];
                        ev_chan <= channel_in;
                        ev_on   <= status_in;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    dropped_out <= data_valid_in;
                    match_hit_q <= match_hit_c;
                    match_idx_q <= match_idx_c;
                    free_hit_q  <= free_hit_c;
                    free_idx_q  <= free_idx_c;
                    old_idx_q   <= old_idx_c;
                    state       <= UPDATE;
                end
                UPDATE: begin
                    dropped_out <= data_valid_in;
                    state       <= IDLE;
                    if (wr_en_c) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == wr_idx_c) begin
                                note_q[i] <= ev_on ? ev_note : 7'd0;
                                vel_q[i]  <= ev_on ? ev_vel : 7'd0;
                                chan_q[i] <= ev_on ? ev_chan : 4'd0;
                                age_q[i]  <= '0;
                            end else if (ev_on && active_q[i] && age_q[i] != AGE_MAX) begin
                                age_q[i] <= age_q[i] + AGE_W'(1);
                            end
                        end
                        active_q         <= next_active_c;
                        active_count_out <= count_c;
                        update_out       <= 1'b1;
                        update_voice_out <= wr_idx_c;
                        stolen_out       <= steal_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice-table model predicts each update,
// and a negedge monitor compares every update_out pulse against the queued prediction.
module tb_voice_allocator;
    localparam int NV      = 8;
    localparam int AGE_MAX = 255;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              data_valid_in = 1'b0;
    logic [7:0]        note_in = '0;
    logic [7:0]        velocity_in = '0;
    logic [3:0]        channel_in = '0;
    logic              status_in = 1'b0;
    logic [NV-1:0]     voice_active_out;
    logic [NV*7-1:0]   voice_note_out;
    logic [NV*7-1:0]   voice_velocity_out;
    logic [NV*4-1:0]   voice_channel_out;
    logic [3:0]        active_count_out;
    logic              update_out;
    logic [2:0]        update_voice_out;
    logic              stolen_out;
    logic              dropped_out;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .note_in(note_in), .velocity_in(velocity_in), .channel_in(channel_in),
        .status_in(status_in), .voice_active_out(voice_active_out),
        .voice_note_out(voice_note_out), .voice_velocity_out(voice_velocity_out),
        .voice_channel_out(voice_channel_out), .active_count_out(active_count_out),
        .update_out(update_out), .update_voice_out(update_voice_out),
        .stolen_out(stolen_out), .dropped_out(dropped_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            idx;
        bit            stolen;
        logic [NV-1:0] act;
        logic [63:0]   notes;
        logic [63:0]   vels;
        logic [63:0]   chans;
        int            cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_drops = 0;
    int   seen_drops = 0;

    int m_act[NV], m_note[NV], m_vel[NV], m_chan[NV], m_age[NV];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0; m_age[i] = 0;
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.idx = 0; e.stolen = 0; e.act = '0; e.notes = '0; e.vels = '0; e.chans = '0; e.cnt = 0;
        for (int i = 0; i < NV; i++) begin
            e.act[i]          = (m_act[i] != 0);
            e.notes[i*7 +: 7] = 7'(m_note[i]);
            e.vels[i*7 +: 7]  = 7'(m_vel[i]);
            e.chans[i*4 +: 4] = 4'(m_chan[i]);
            e.cnt += m_act[i];
        end
        return e;
    endfunction

    // Apply one accepted event to the voice table following the allocation rules.
    task automatic model_event(input int n, input int v, input int c, input bit on);
        int hit = -1, fr = -1, old = -1, tgt;
        bit st = 0;
        exp_t e;
        if (n > 127) return;
        v = v % 128;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] != 0 && m_note[i] == n && m_chan[i] == c && hit < 0) hit = i;
            if (m_act[i] == 0 && fr < 0) fr = i;
            if (m_act[i] != 0 && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (on) begin
            if (hit >= 0) tgt = hit;
            else if (fr >= 0) tgt = fr;
            else begin tgt = old; st = 1; end
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_act[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            m_act[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v; m_chan[tgt] = c; m_age[tgt] = 0;
        end else begin
            if (hit < 0) return;
            tgt = hit;
            m_act[tgt] = 0; m_note[tgt] = 0; m_vel[tgt] = 0; m_chan[tgt] = 0; m_age[tgt] = 0;
        end
        e = snapshot();
        e.idx = tgt;
        e.stolen = st;
        q.push_back(e);
    endtask

    task automatic drive(input int n, input int v, input int c, input bit on);
        @(negedge clk_in);
        note_in = 8'(n); velocity_in = 8'(v); channel_in = 4'(c); status_in = on;
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
    endtask

    task automatic check_table(input string tag);
        exp_t e;
        e = snapshot();
        chk({tag, "_active"}, 64'(voice_active_out), 64'(e.act));
        chk({tag, "_notes"}, 64'(voice_note_out), e.notes);
        chk({tag, "_vels"}, 64'(voice_velocity_out), e.vels);
        chk({tag, "_chans"}, 64'(voice_channel_out), e.chans);
        chk({tag, "_count"}, 64'(active_count_out), 64'(e.cnt));
    endtask

    // Drive an event, record its prediction, and wait until the DUT can accept the next one.
    task automatic send(input int n, input int v, input int c, input bit on);
        drive(n, v, c, on);
        model_event(n, v, c, on);
        @(negedge clk_in);
        @(negedge clk_in);
        check_table("table");
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        data_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("reset_outputs",
            {voice_active_out, active_count_out, update_out, update_voice_out, stolen_out, dropped_out},
            '0);
        chk("reset_table", voice_note_out | voice_velocity_out | 64'(voice_channel_out), '0);
        model_clear();
        q.delete();
        rst_in = 1'b0;
    endtask

    // Monitor: every update pulse must correspond to the next queued prediction.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            if (dropped_out) seen_drops++;
            if (stolen_out && !update_out) begin
                checks++; errors++;
                $display("FAIL stolen_without_update got 1 expected 0 at %0t", $time);
            end
            if (update_out) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update got voice %0d expected none at %0t",
                             update_voice_out, $time);
                end else begin
                    e = q.pop_front();
                    chk("upd_voice", 64'(update_voice_out), 64'(e.idx));
                    chk("upd_stolen", 64'(stolen_out), 64'(e.stolen));
                    chk("upd_active", 64'(voice_active_out), 64'(e.act));
                    chk("upd_notes", 64'(voice_note_out), e.notes);
                    chk("upd_vels", 64'(voice_velocity_out), e.vels);
                    chk("upd_chans", 64'(voice_channel_out), e.chans);
                    chk("upd_count", 64'(active_count_out), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        do_reset();

        // Single note-on lands in voice 0.
        send(60, 100, 0, 1);
        chk("first_note", 64'(voice_note_out[6:0]), 64'd60);
        chk("first_vel", 64'(voice_velocity_out[6:0]), 64'd100);
        chk("first_count", 64'(active_count_out), 64'd1);

        // Note-off of voice 0 leaves voice 1; unmatched note-off is silent.
        do_reset();
        send(60, 100, 0, 1);
        send(64, 80, 0, 1);
        send(60, 0, 0, 0);
        chk("off_v1_note", 64'(voice_note_out[13:7]), 64'd64);
        send(72, 0, 0, 0);

        // Ninth note steals the oldest voice.
        do_reset();
        for (int i = 0; i < 9; i++) send(36 + i, 90, 0, 1);
        chk("steal_note", 64'(voice_note_out[6:0]), 64'd44);
        chk("steal_count", 64'(active_count_out), 64'd8);

        // Retrigger on the same note and channel reuses the voice.
        do_reset();
        send(60, 50, 3, 1);
        send(60, 90, 3, 1);
        chk("retrig_vel", 64'(voice_velocity_out[6:0]), 64'd90);

        // Note 0 and velocity MSB masking.
        send(0, 255, 15, 1);

        // Second event while busy is dropped.
        drive(70, 60, 2, 1);
        note_in = 8'd71; data_valid_in = 1'b1;
        exp_drops++;
        model_event(70, 60, 2, 1);
        @(negedge clk_in);
        data_valid_in = 1'b0;
        chk("drop_pulse", 64'(dropped_out), 64'd1);
        @(negedge clk_in);
        check_table("drop");

        // Reset right after an event abandons it.
        drive(50, 40, 1, 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("abandon_outputs",
            {voice_active_out, active_count_out, update_out, stolen_out, dropped_out}, '0);
        model_clear();
        q.delete();
        rst_in = 1'b0;
        send(50, 40, 1, 1);

        // Randomized traffic with frequent collisions, ignored high notes and stealing.
        for (int i = 0; i < 300; i++) begin
            int n, v, c;
            bit on;
            n  = 36 + int'($urandom_range(0, 13));
            v  = int'($urandom_range(0, 255));
            c  = int'($urandom_range(0, 1));
            on = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0) n = 128 + n;
            send(n, v, c, on);
        end

        repeat (4) @(negedge clk_in);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("drop_total", 64'(seen_drops), 64'(exp_drops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter: NUM_VOICES, default 8, number of polyphonic voice slots (2..16).
REQ-002 Parameter: AGE_W, default 8, width of each voice's saturating age counter.
REQ-003 clk_in  input  1  system clock, 100 MHz; one clock; all logic on posedge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 data_valid_in  input  1  one-cycle pulse; note event present on the inputs below.
REQ-006 note_in  input  8  MIDI note number.
REQ-007 velocity_in  input  8  MIDI velocity.
REQ-008 channel_in  input  4  MIDI channel.
REQ-009 status_in  input  1  1 = note-on, 0 = note-off (including velocity 0).
REQ-010 voice_active_out  output  NUM_VOICES  per-voice occupied flag.
REQ-011 voice_note_out  output  NUM_VOICES x 7  per-voice note, packed, voice 0 in the LSBs.
REQ-012 voice_velocity_out  output  NUM_VOICES x 7  per-voice velocity, packed.
REQ-013 voice_channel_out  output  NUM_VOICES x 4  per-voice channel, packed.
REQ-014 active_count_out  output  $clog2(NUM_VOICES+1)  number of active voices.
REQ-015 update_out  output  1  one-cycle pulse; the voice table changed.
REQ-016 update_voice_out  output  $clog2(NUM_VOICES)  index of the voice written; valid while update_out is high.
REQ-017 stolen_out  output  1  one-cycle pulse with update_out; an active voice was reassigned.
REQ-018 dropped_out  output  1  one-cycle pulse; an incoming event was discarded because the block was busy.

Function
REQ-019 The FSM SHALL have three states: IDLE, SEARCH and UPDATE; the default state is IDLE.
REQ-020 IDLE: on data_valid_in, SHALL latch note[6:0], velocity[6:0], channel and status, then go to SEARCH. If note_in[7]=1, the event SHALL be ignored and the FSM stays in IDLE.
REQ-021 SEARCH: SHALL register three results over all voices, then go to UPDATE: the match index (active voice with equal note and channel), the lowest-index free voice, and the oldest active voice (maximum age; ties go to the lowest index).
REQ-022 UPDATE: SHALL write the table, pulse update_out, then return to IDLE.
REQ-023 Latency: for data_valid_in high in cycle k, the updated outputs and update_out SHALL be visible in cycle k+3, and a new event SHALL be accepted from cycle k+3.
REQ-024 data_valid_in in SEARCH or UPDATE SHALL leave the latched event untouched and SHALL pulse dropped_out in the next cycle.
REQ-025 Note-on with a match: SHALL rewrite velocity in the matched voice, set its age to 0, and SHALL NOT pulse stolen_out.
REQ-026 Note-on with no match and a free voice: SHALL write note, velocity and channel into the lowest free voice and set it active with age 0.
REQ-027 Note-on with no match and no free voice: SHALL overwrite the oldest voice and pulse stolen_out.
REQ-028 On any note-on write, every other active voice's age SHALL increment by 1, saturating at 2^AGE_W-1.
REQ-029 Note-off with a match: SHALL clear the voice's active flag, note, velocity, channel and age to 0, and SHALL pulse update_out.
REQ-030 Note-off without a match: SHALL make no table change and SHALL pulse neither update_out nor stolen_out.
REQ-031 active_count_out SHALL be registered and SHALL equal the popcount of voice_active_out in the same cycle.
REQ-032 Note 0 SHALL be a legal note number.
REQ-033 Velocity SHALL be stored as velocity_in[6:0].

Reset
REQ-034 While rst_in is high: the FSM SHALL go to IDLE, all voice fields and ages SHALL be 0, and all outputs SHALL be 0.
REQ-035 Reset asserted in SEARCH or UPDATE SHALL abandon the event with no table write and no update_out.
REQ-036 The first event SHALL be accepted in the cycle after rst_in deasserts.

Verification
REQ-037 Reset, then note-on note 60, velocity 100, channel 0 -> in cycle k+3: voice 0 active with note 60 and velocity 100, update_out=1, update_voice_out=0, active_count_out=1.
REQ-038 Note-ons 60 then 64, then note-off 60 -> voice 0 cleared, voice 1 keeps 64, active_count_out=1; a later note-off 72 -> no update_out.
REQ-039 Nine distinct note-ons (36..44) with NUM_VOICES=8 -> ninth note overwrites voice 0 (note 36), stolen_out=1, active_count_out=8.
REQ-040 Note-on 60 velocity 50, then note-on 60 velocity 90 on the same channel -> same voice, velocity 90, active_count_out=1, no steal.
REQ-041 Second data_valid_in one cycle after the first -> dropped_out pulses once; only the first event is applied.
REQ-042 rst_in asserted in the cycle after data_valid_in -> no update_out and all outputs 0; the next event after reset is processed normally.
